// File: rtl/quad_speed_sampler.sv
// rtl/quad_speed_sampler.sv - windowed signed step counter behind the quadrature decoder
//
// Purpose: accumulates +1/-1 decoder steps over a window of period*TICK_DIV
// clocks and publishes the saturated total with a one-cycle valid strobe.
// Optional feature macro: QUAD_POS_ACCUM_EN adds a free-running 32-bit position.
//
// Ports:
//   clk        clock
//   reset      synchronous reset, active low
//   en         sampling enable
//   period     window length in ticks, 0 disables windowing
//   pulse_in   one-cycle step strobe
//   dir_in     step direction, 1 = forward
//   pos_clr    (QUAD_POS_ACCUM_EN) clear position, drops a same-cycle pulse
//   position   (QUAD_POS_ACCUM_EN) signed running position, wraps mod 2^32
//   count      signed steps in the last completed window
//   valid      one-cycle strobe, count just updated
module quad_speed_sampler #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 8,
  parameter int TICK_DIV     = 50000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [PERIOD_WIDTH-1:0]        period,
  input  logic                           pulse_in,
  input  logic                           dir_in,
`ifdef QUAD_POS_ACCUM_EN
  input  logic                           pos_clr,
  output logic signed [31:0]             position,
`endif
  output logic signed [COUNT_WIDTH-1:0]  count,
  output logic                           valid
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [COUNT_WIDTH-1:0] SAT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] SAT_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [TW-1:0]            r_tick_cnt;
  logic [PERIOD_WIDTH-1:0]  r_win_cnt;
  logic [PERIOD_WIDTH-1:0]  r_per_q;
  logic [COUNT_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_valid;

  logic                     w_start;
  logic                     w_stop;
  logic                     w_tick;
  logic                     w_win_end;
  logic [COUNT_WIDTH:0]     w_sum_ext;
  logic [COUNT_WIDTH-1:0]   w_acc_sat;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // One extra bit on the sum; overflow shows up as the top two bits differing.
  always_comb begin
    w_sum_ext = {r_acc[COUNT_WIDTH-1], r_acc};
    if (pulse_in) begin
      if (dir_in) w_sum_ext = w_sum_ext + (COUNT_WIDTH+1)'(1);
      else        w_sum_ext = w_sum_ext - (COUNT_WIDTH+1)'(1);
    end
    if (w_sum_ext[COUNT_WIDTH] != w_sum_ext[COUNT_WIDTH-1])
      w_acc_sat = w_sum_ext[COUNT_WIDTH] ? SAT_MIN : SAT_MAX;
    else
      w_acc_sat = w_sum_ext[COUNT_WIDTH-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_win_end   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (en && (period != '0)) begin
        w_state_nxt = ST_RUN;
        w_start     = 1'b1;
      end
    end else begin
      // Leaving RUN wins over a coincident window end: the window is dropped.
      if (!en || (period == '0)) begin
        w_state_nxt = ST_IDLE;
        w_stop      = 1'b1;
      end else begin
        w_win_end = w_tick && (r_win_cnt == (r_per_q - PERIOD_WIDTH'(1)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_win_cnt  <= '0;
      r_per_q    <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_start) begin
        r_per_q    <= period;
        r_acc      <= '0;
        r_tick_cnt <= '0;
        r_win_cnt  <= '0;
      end else if (w_stop) begin
        r_acc      <= '0;
        r_tick_cnt <= '0;
        r_win_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        if (w_win_end) begin
          // A pulse on the closing cycle still belongs to this window.
          r_count   <= w_acc_sat;
          r_valid   <= 1'b1;
          r_acc     <= '0;
          r_win_cnt <= '0;
          r_per_q   <= period;
        end else begin
          r_acc <= w_acc_sat;
          if (w_tick) r_win_cnt <= r_win_cnt + PERIOD_WIDTH'(1);
        end
      end
    end
  end

  assign count = r_count;
  assign valid = r_valid;

`ifdef QUAD_POS_ACCUM_EN
  logic [31:0] r_position;

  always_ff @(posedge clk) begin
    if (!reset)              r_position <= '0;
    else if (pos_clr)        r_position <= '0;
    else if (en && pulse_in) r_position <= dir_in ? r_position + 32'd1 : r_position - 32'd1;
  end

  assign position = r_position;
`endif

endmodule

// File: tb/tb_quad_speed_sampler.sv
// tb/tb_quad_speed_sampler.sv - self-checking bench for quad_speed_sampler
module tb_quad_speed_sampler;

    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [7:0]        period;
    logic              pulse_in;
    logic              dir_in;
    logic signed [15:0] count16;
    logic              valid16;
    logic signed [3:0] count4;
    logic              valid4;
`ifdef QUAD_POS_ACCUM_EN
    logic              pos_clr;
    logic signed [31:0] pos16;
    logic signed [31:0] pos4;
`endif

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    logic prev_valid = 1'b0;

    typedef struct { int c16; int c4; int at; } exp_t;
    typedef struct { int per; int nf; int nr; int c16; int c4; } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    quad_speed_sampler #(.COUNT_WIDTH(16), .PERIOD_WIDTH(8), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(rst_n), .en(en), .period(period),
        .pulse_in(pulse_in), .dir_in(dir_in),
`ifdef QUAD_POS_ACCUM_EN
        .pos_clr(pos_clr), .position(pos16),
`endif
        .count(count16), .valid(valid16));

    quad_speed_sampler #(.COUNT_WIDTH(4), .PERIOD_WIDTH(8), .TICK_DIV(TD)) dut4 (
        .clk(clk), .reset(rst_n), .en(en), .period(period),
        .pulse_in(pulse_in), .dir_in(dir_in),
`ifdef QUAD_POS_ACCUM_EN
        .pos_clr(pos_clr), .position(pos4),
`endif
        .count(count4), .valid(valid4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid16 && prev_valid) chk("valid_consecutive", 1, 0);
        prev_valid = valid16;
        if (valid16 || valid4) begin
            chk("valid_pair", int'(valid4), int'(valid16));
            if (sb.size() == 0) begin
                chk("unexpected_valid", cyc, -1);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.at);
                chk("count16", int'(count16), e.c16);
                chk("count4", int'(count4), e.c4);
            end
        end
    end

    task automatic wait_until(int t);
        int guard = 0;
        while (cyc < t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) chk("timeout", cyc, t);
    endtask

    task automatic push_exp(int c16, int c4, int at);
        exp_t e;
        e.c16 = c16; e.c4 = c4; e.at = at;
        sb.push_back(e);
    endtask

    task automatic pulse(logic d);
        @(negedge clk);
        pulse_in = 1'b1;
        dir_in   = d;
    endtask

    task automatic run_vec(vec_t v);
        int k;
        @(negedge clk);
        en = 1'b1; period = 8'(v.per); pulse_in = 1'b0;
        k = cyc + 1;
        push_exp(v.c16, v.c4, k + v.per * TD);
        for (int i = 0; i < v.nf + v.nr; i++) pulse(i < v.nf);
        @(negedge clk);
        pulse_in = 1'b0;
        wait_until(k + v.per * TD);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0; en = 1'b0; period = '0; pulse_in = 1'b0; dir_in = 1'b0;
`ifdef QUAD_POS_ACCUM_EN
        pos_clr = 1'b0;
`endif
        vecs[0] = '{2, 5,  0,   5,  5};
        vecs[1] = '{3, 3,  7,  -4, -4};
        vecs[2] = '{8, 12, 0,  12,  7};
        vecs[3] = '{8, 0,  20, -20, -8};
        vecs[4] = '{1, 0,  0,   0,  0};
        vecs[5] = '{4, 9,  2,   7,  5};
        vecs[6] = '{2, 0,  8,  -8, -8};
        vecs[7] = '{2, 8,  0,   8,  7};

        // Reset held with activity on the inputs.
        en = 1'b1; period = 8'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_count16", int'(count16), 0);
            chk("rst_valid16", int'(valid16), 0);
            pulse_in = 1'($urandom_range(0, 1));
            dir_in   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pulse_in = 1'($urandom_range(0, 1));
            dir_in   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        pulse_in = 1'b0;
        chk("idle_count16", int'(count16), 0);
        chk("idle_count4", int'(count4), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back windows: the empty second window reports 0 eight cycles later.
        @(negedge clk);
        en = 1'b1; period = 8'd2; k = cyc + 1;
        push_exp(5, 5, k + 8);
        push_exp(0, 0, k + 16);
        repeat (5) pulse(1'b1);
        @(negedge clk); pulse_in = 1'b0;
        wait_until(k + 16);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Pulse on the closing cycle vs. the first cycle of the next window.
        en = 1'b1; period = 8'd3; k = cyc + 1;
        push_exp(1, 1, k + 12);
        push_exp(-1, -1, k + 24);
        wait_until(k + 11);
        pulse_in = 1'b1; dir_in = 1'b1;
        @(negedge clk); pulse_in = 1'b1; dir_in = 1'b0;
        @(negedge clk); pulse_in = 1'b0;
        wait_until(k + 24);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Period change lands at the boundary; period 0 mid-window drops it.
        en = 1'b1; period = 8'd2; k = cyc + 1;
        push_exp(0, 0, k + 8);
        wait_until(k + 3);
        period = 8'd4;
        wait_until(k + 8);
        push_exp(3, 3, k + 24);
        pulse_in = 1'b1; dir_in = 1'b1;
        repeat (2) pulse(1'b1);
        @(negedge clk); pulse_in = 1'b0;
        wait_until(k + 24);
        repeat (2) pulse(1'b1);
        @(negedge clk); pulse_in = 1'b0;
        wait_until(k + 30);
        period = 8'd0;
        wait_until(k + 45);
        chk("hold_count16", int'(count16), 3);
        chk("hold_count4", int'(count4), 3);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-window discards the partial accumulation.
        en = 1'b1; period = 8'd2;
        repeat (3) pulse(1'b1);
        @(negedge clk);
        pulse_in = 1'b0; rst_n = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_count16", int'(count16), 0);
        run_vec('{2, 1, 0, 1, 1});

`ifdef QUAD_POS_ACCUM_EN
        en = 1'b1; period = 8'd0;
        @(negedge clk); pos_clr = 1'b1; pulse_in = 1'b1; dir_in = 1'b1;
        @(negedge clk); pos_clr = 1'b0; pulse_in = 1'b0;
        for (int i = 0; i < 13; i++) pulse(i < 10);
        @(negedge clk); pulse_in = 1'b0;
        chk("position_7", int'(pos16), 7);
        pos_clr = 1'b1; pulse_in = 1'b1; dir_in = 1'b1;
        @(negedge clk); pos_clr = 1'b0; pulse_in = 1'b0;
        chk("position_clr", int'(pos16), 0);
        pulse(1'b0);
        @(negedge clk); pulse_in = 1'b0;
        chk("position_neg1", int'(pos16), -1);
        en = 1'b0;
        repeat (2) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
